// File: rtl/instr_encoder_if.sv
// Field-bundle handshake plus instruction-memory write port of instr_encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              clear;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              err;

  modport master (
    output in_valid, in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output clear,
    input  in_ready, imem_we, imem_addr, imem_wdata, done, count, err
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  clear,
    output in_ready, imem_we, imem_addr, imem_wdata, done, count, err
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder that writes packed words to consecutive imem addresses.
// Define INSTR_ENC_CHECK_EN to reject out-of-range fields and raise the sticky err flag.
module instr_encoder #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus_io
);

  localparam logic [ADDR_W:0] LastCnt = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        in_ready, accept, enc_err;
  logic [31:0] enc_word, imm;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd, rs1, rs2;

  assign imm = bus_io.in_imm;
  assign f3  = bus_io.in_funct3;
  assign f7  = bus_io.in_funct7;
  assign rd  = bus_io.in_rd;
  assign rs1 = bus_io.in_rs1;
  assign rs2 = bus_io.in_rs2;
  assign accept = bus_io.in_valid & in_ready;

  always_comb begin
    enc_word = 32'h0000_0013;
    case (bus_io.in_kind)
      4'd0: enc_word = {f7, rs2, rs1, f3, rd, 7'b0110011};
      4'd1: begin
        if (f3 == 3'b001 || f3 == 3'b101) enc_word = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
        else                              enc_word = {imm[11:0], rs1, f3, rd, 7'b0010011};
      end
      4'd2: enc_word = {imm[11:0], rs1, f3, rd, 7'b0000011};
      4'd3: enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      4'd4: enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      4'd5: enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      4'd6: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      4'd7: enc_word = {imm[31:12], rd, 7'b0110111};
      4'd8: enc_word = {imm[31:12], rd, 7'b0010111};
      default: enc_word = 32'h0000_0013;
    endcase
  end

`ifdef INSTR_ENC_CHECK_EN
  logic sx12, sx13, sx21;
  assign sx12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign sx13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign sx21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  always_comb begin
    enc_err = 1'b1;
    case (bus_io.in_kind)
      4'd0:             enc_err = 1'b0;
      4'd1: begin
        if (f3 == 3'b001 || f3 == 3'b101) enc_err = (imm[31:5] != '0);
        else                              enc_err = ~sx12;
      end
      4'd2, 4'd3, 4'd5: enc_err = ~sx12;
      4'd4:             enc_err = ~sx13 | imm[0];
      4'd6:             enc_err = ~sx21 | imm[0];
      4'd7, 4'd8:       enc_err = (imm[11:0] != '0);
      default:          enc_err = 1'b1;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!enc_err)                 state_d = StWrite;
          else if (bus_io.in_last)      state_d = StDone;
        end
      end
      StWrite: state_d = (last_q || count_q == LastCnt) ? StDone : StIdle;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (bus_io.clear) state_d = StIdle;
  end

  always_comb begin
    in_ready = (state_q == StIdle) & ~bus_io.clear;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    err_d    = err_q;
    if (accept) begin
      last_d = bus_io.in_last;
      if (enc_err) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        wdata_d = enc_word;
      end
    end
    // Pointer holds at the last word once full; only clear brings it back to 0.
    if (state_q == StWrite) begin
      count_d = count_q + 1'b1;
      if (count_q != LastCnt) ptr_d = ptr_q + 1'b1;
    end
    if (bus_io.clear) begin
      ptr_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      wdata_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.in_ready   = in_ready;
  assign bus_io.imem_we    = we_q;
  assign bus_io.imem_addr  = ptr_q;
  assign bus_io.imem_wdata = wdata_q;
  assign bus_io.done       = done_q;
  assign bus_io.count      = count_q;
  assign bus_io.err        = err_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Sequential RV32I instruction encoder and instruction-memory loader; the inverse of the control-unit decode path.
- Accepts instruction fields (format kind, rd, rs1, rs2, funct3, funct7, full 32-bit immediate) over a valid/ready handshake.
- Packs each into a 32-bit RV32I word, including the scrambled S/B/J immediate layouts, and writes it to consecutive instruction-memory addresses.
- Used as a boot-time program loader and as a stimulus generator for the single-cycle core.

## Interface
- `DEPTH`, 256: instruction-memory depth in words; power of two, ≥ 2.
- `ADDR_W`, 8: word-address width, equal to log2(DEPTH).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  block can accept a bundle.
- `in_kind`  in  4  format code:
  - 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 jalr, 6 jal, 7 lui, 8 auipc.
  - 9–15 illegal.
- `in_funct3`  in  3  funct3 field.
- `in_funct7`  in  7  funct7 field.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  32  immediate, as a byte offset or value.
- `in_last`  in  1  this bundle ends the program.
- `clear`  in  1  synchronous restart: address, count and error return to 0.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address of the current write.
- `imem_wdata`  out  32  encoded instruction.
- `done`  out  1  program complete or memory full.
- `count`  out  ADDR_W+1  number of words written.
- `err`  out  1  sticky encoding error; only active with the configuration macro.

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - `in_ready = ~clear`.
  - On `in_valid & in_ready`, register the encoded word and go to WRITE.
- WRITE:
  - `imem_we=1` for exactly one cycle, with `imem_addr` = write pointer.
  - Then pointer+1 and count+1.
  - Go to DONE if `in_last` was set on the accepted bundle or count reaches DEPTH; otherwise go to IDLE.
- DONE:
  - `in_ready=0`, `done=1`; `in_valid` is ignored.
  - Leaves only on `clear`.
- `clear` in any state:
  - Next state IDLE; pointer, count, `done` and `err` are set to 0.
  - A write already in progress that cycle still completes.
- Encoding; `{}` is concatenation MSB first, all immediates taken from `in_imm` bits:
  - R: `{funct7, rs2, rs1, f3, rd, 0110011}`.
  - I-ALU: `{imm[11:0], rs1, f3, rd, 0010011}`. When f3 = 001 or 101, bits [31:25] = funct7 and [24:20] = imm[4:0].
  - Load: as I with opcode 0000011.
  - jalr: as I with f3 forced to 000, opcode 1100111.
  - Store: `{imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}`.
  - Branch: `{imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}`.
  - jal: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}`.
  - lui / auipc: `{imm[31:12], rd, 0110111 / 0010111}`.
- Fields that a format does not use are ignored.
- Illegal kind: writes NOP 0x00000013 (see Configuration for the alternative).

## Timing
- Reset values:
  - state IDLE, `in_ready=1`.
  - `imem_we=0`, `imem_addr=0`, `imem_wdata=0`.
  - `done=0`, `count=0`, `err=0`.
- Reset acts immediately and asynchronously, including mid-WRITE.
- Bundle accepted at edge N → `imem_we` high during cycle N+1 → `in_ready` high again in N+2, unless the block has entered DONE.
- Peak throughput: one word per 2 cycles.
- All outputs are registered except `in_ready`.
- `done` rises in the cycle after the final write.
- `count` reads DEPTH exactly when full; the pointer wraps to 0 only through `clear`.

## Configuration
- `INSTR_ENC_CHECK_EN` defined → a field check runs at acceptance. An error is raised when:
  - the kind is illegal; or
  - I/S/jalr imm is not a sign-extended 12-bit value; or
  - B imm is not a sign-extended 13-bit value or imm[0]=1; or
  - J imm is not a sign-extended 21-bit value or imm[0]=1; or
  - U imm[11:0]≠0; or
  - a shift has imm[31:5]≠0.
- On an error:
  - The bundle is consumed but not written; pointer and count are unchanged.
  - `err` goes high and stays high until `clear` or reset.
  - If `in_last` was set, go to DONE.
- Macro undefined → `err` tied to 0; out-of-range bits are silently truncated; illegal kinds write a NOP.

## Test plan
- R `add x3,x1,x2` (kind 0, f3 0, f7 0) → `imem_wdata=0x002081B3`, `imem_addr=0`, `imem_we` high for one cycle, `count=1`.
- Branch `beq x1,x2,-4` (kind 4, imm 0xFFFFFFFC), then lui `x5,0x12345000` with `in_last=1`:
  - words 0xFE208EE3 at addr 0 and 0x123452B7 at addr 1.
  - `done=1`, `count=2`, `in_ready=0`.
- DEPTH back-to-back bundles with `in_last=0` → after write DEPTH−1, `done=1` and `count=DEPTH`; an extra `in_valid` produces no write.
- `clear` pulsed while `in_valid=1` → bundle not accepted, `addr=0`, `count=0`, `done=0`.
- Branch with imm=3:
  - with `INSTR_ENC_CHECK_EN`: no write, `err=1`, count unchanged.
  - without it: word with imm[0] dropped is written, `err=0`.
- `rst_n` driven low while `imem_we=1` → `imem_we`, `imem_addr` and `count` are 0 immediately; after release `in_ready=1`.
